barker_frame_tx: RTL and testbench

//  Transmit side of the Barker-11 link. Takes payload words on an AXI-Stream slave and emits
//  a serial 1-bit frame: 11-bit Barker preamble (11'b11100010010, MSB first), then payload

---
 rtl/barker_frame_tx.sv | 171 +++++++++++++++++
 tb/tb_barker_frame_tx.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/barker_frame_tx.sv
// Barker-11 frame transmitter: buffers AXI-Stream payload words and serialises each frame
// as an 11-bit Barker preamble followed by the payload bits, MSB first.
module barker_frame_tx #(
  parameter int DATA_W     = 8,
  parameter int IFG_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tvalid,
  input  logic              s_tlast,
  output logic              s_tready,
  output logic              m_tdata,
  output logic              m_tvalid,
  output logic              m_tlast,
  output logic              m_tuser,
  input  logic              m_tready,
  output logic              o_busy,
  output logic              o_underrun,
  output logic [2:0]        o_dbg_state
);

  // Handshakes: a transfer happens on an edge where valid & ready are both high; once
  // m_tvalid is raised, m_tdata/m_tlast/m_tuser stay stable until the transfer completes.

  typedef enum logic [2:0] {IDLE, PRE, DATA, WAIT, GAP} state_t;

  localparam int CNT_W = $clog2(DATA_W);
  localparam int GAP_W = (IFG_CYCLES > 0) ? $clog2(IFG_CYCLES + 1) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  // 11'b11100010010 zero-extended so any 4-bit index is in range
  localparam logic [15:0] BARKER = 16'h0712;

  state_t             state_q, state_n;
  logic [3:0]         idx_q, idx_n;
  logic [DATA_W-1:0]  shift_q, shift_n;
  logic               wlast_q, wlast_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [GAP_W-1:0]   gap_q, gap_n;
  logic               hold_v, hold_last;
  logic [DATA_W-1:0]  hold_data;
  logic               load, capture, adv, underrun_n;
  logic               tvalid_n, tdata_n, tlast_n, tuser_n;

  assign s_tready    = i_rst_n & ~hold_v;
  assign capture     = s_tvalid & s_tready;
  assign adv         = m_tvalid & m_tready;
  assign o_busy      = (state_q != IDLE);
  assign o_dbg_state = state_q;

  always_comb begin
    state_n    = state_q;
    idx_n      = idx_q;
    shift_n    = shift_q;
    wlast_n    = wlast_q;
    cnt_n      = cnt_q;
    gap_n      = gap_q;
    load       = 1'b0;
    underrun_n = 1'b0;
    case (state_q)
      IDLE: begin
        if (hold_v) begin
          state_n = PRE;
          idx_n   = 4'd10;
        end
      end
      PRE: begin
        if (adv) begin
          if (idx_q == 4'd0) begin
            if (hold_v) begin
              load    = 1'b1;
              state_n = DATA;
            end else begin
              state_n = WAIT;
            end
          end else begin
            idx_n = idx_q - 4'd1;
          end
        end
      end
      DATA: begin
        if (adv) begin
          if (cnt_q == '0) begin
            if (wlast_q) begin
              state_n = (IFG_CYCLES > 0) ? GAP : IDLE;
              gap_n   = '0;
            end else if (hold_v) begin
              load = 1'b1;
            end else begin
              state_n    = WAIT;
              underrun_n = 1'b1;
            end
          end else begin
            shift_n = {shift_q[DATA_W-2:0], 1'b0};
            cnt_n   = cnt_q - 1'b1;
          end
        end
      end
      WAIT: begin
        if (hold_v) begin
          load    = 1'b1;
          state_n = DATA;
        end
      end
      GAP: begin
        if (gap_q == GAP_LAST) state_n = IDLE;
        else                   gap_n   = gap_q + 1'b1;
      end
      default: state_n = IDLE;
    endcase
    if (load) begin
      shift_n = hold_data;
      wlast_n = hold_last;
      cnt_n   = CNT_W'(DATA_W - 1);
    end
  end

  // Outputs are precomputed from next-state values so they are registered yet cycle-exact.
  always_comb begin
    tvalid_n = (state_n == PRE) || (state_n == DATA);
    tdata_n  = 1'b0;
    if (state_n == PRE)       tdata_n = BARKER[idx_n];
    else if (state_n == DATA) tdata_n = shift_n[DATA_W-1];
    tuser_n  = (state_n == PRE) && (idx_n == 4'd0);
    tlast_n  = (state_n == DATA) && wlast_n && (cnt_n == '0);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      shift_q    <= '0;
      wlast_q    <= 1'b0;
      cnt_q      <= '0;
      gap_q      <= '0;
      m_tvalid   <= 1'b0;
      m_tdata    <= 1'b0;
      m_tlast    <= 1'b0;
      m_tuser    <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      state_q    <= state_n;
      idx_q      <= idx_n;
      shift_q    <= shift_n;
      wlast_q    <= wlast_n;
      cnt_q      <= cnt_n;
      gap_q      <= gap_n;
      m_tvalid   <= tvalid_n;
      m_tdata    <= tdata_n;
      m_tlast    <= tlast_n;
      m_tuser    <= tuser_n;
      o_underrun <= underrun_n;
    end
  end

  // A capture and a load cannot coincide (capture needs an empty holder), capture wins anyway.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hold_v    <= 1'b0;
      hold_data <= '0;
      hold_last <= 1'b0;
    end else if (capture) begin
      hold_v    <= 1'b1;
      hold_data <= s_tdata;
      hold_last <= s_tlast;
    end else if (load) begin
      hold_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_barker_frame_tx.sv
// Directed bench for barker_frame_tx: serial frame content, stalls, underrun, frame gap, reset.
module tb_barker_frame_tx;

  localparam int IFG = 2;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic [7:0] s_tdata = '0;
  logic       s_tvalid = 1'b0;
  logic       s_tlast = 1'b0;
  logic       s_tready;
  logic       m_tdata, m_tvalid, m_tlast, m_tuser;
  logic       m_tready = 1'b1;
  logic       o_busy, o_underrun;
  logic [2:0] o_dbg_state;

  logic       got_bit[$], got_user[$], got_last[$];
  int         got_cyc[$];
  logic       exp_q[$], exp_u[$], exp_l[$];
  logic [10:0] barker_v = 11'b11100010010;
  int         checks = 0, fails = 0;
  int         stall_err, underruns;
  logic       uv_valid;
  bit         to;

  barker_frame_tx #(.DATA_W(8), .IFG_CYCLES(IFG)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tready(m_tready), .o_busy(o_busy), .o_underrun(o_underrun), .o_dbg_state(o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic void exp_clear();
    exp_q.delete(); exp_u.delete(); exp_l.delete();
  endfunction

  function automatic void exp_preamble();
    for (int i = 10; i >= 0; i--) begin
      exp_q.push_back(barker_v[i]); exp_u.push_back(i == 0); exp_l.push_back(1'b0);
    end
  endfunction

  function automatic void exp_word(input logic [7:0] w, input logic last);
    for (int i = 7; i >= 0; i--) begin
      exp_q.push_back(w[i]); exp_u.push_back(1'b0); exp_l.push_back(last && i == 0);
    end
  endfunction

  task automatic send_word(input logic [7:0] d, input logic l);
    bit done = 0;
    @(negedge i_clk);
    s_tdata = d; s_tlast = l; s_tvalid = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      if (i > 0) @(negedge i_clk);
      done = s_tready;
      @(posedge i_clk); #1;
    end
    s_tvalid = 1'b0;
    checks++;
    if (!done) begin
      fails++;
      $display("FAIL send_word accept got s_tready=0 want 1 within 300 cycles (data %h)", d);
    end
  endtask

  // mode 0: m_tready always 1; mode 1: m_tready high one cycle in three
  task automatic capture(input int mode, input int max_hs, input int nlast, input int budget,
                         output bit timed_out);
    int hs = 0, lasts = 0;
    logic pd, pu, pl;
    bit stalled = 0;
    got_bit.delete(); got_user.delete(); got_last.delete(); got_cyc.delete();
    stall_err = 0; underruns = 0; uv_valid = 1'b1; timed_out = 1;
    pd = 0; pu = 0; pl = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge i_clk);
      m_tready = (mode == 0) ? 1'b1 : (c % 3 == 0);
      if (stalled && !(m_tvalid === 1'b1 && m_tdata === pd && m_tuser === pu && m_tlast === pl))
        stall_err++;
      if (o_underrun === 1'b1) begin
        underruns++;
        uv_valid = m_tvalid;
      end
      stalled = m_tvalid && !m_tready;
      pd = m_tdata; pu = m_tuser; pl = m_tlast;
      if (m_tvalid === 1'b1 && m_tready) begin
        got_bit.push_back(m_tdata); got_user.push_back(m_tuser); got_last.push_back(m_tlast);
        got_cyc.push_back(c);
        hs++;
        if (m_tlast === 1'b1) lasts++;
        if (lasts == nlast || hs == max_hs) begin
          timed_out = 0;
          break;
        end
      end
    end
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tuser, o_busy, o_underrun, s_tready} !== 7'b0) begin
      fails++;
      $display("FAIL reset_outputs got v/d/l/u/busy/ur/rdy=%b%b%b%b%b%b%b want 0000000",
               m_tvalid, m_tdata, m_tlast, m_tuser, o_busy, o_underrun, s_tready);
    end
    checks++;
    if (o_dbg_state !== 3'd0) begin
      fails++; $display("FAIL reset_state got %0d want 0", o_dbg_state);
    end
    i_rst_n = 1'b1;
    #1;
    checks++;
    if (s_tready !== 1'b1) begin
      fails++; $display("FAIL reset_release_ready got %b want 1", s_tready);
    end
  endtask

  task automatic test_single_frame();
    exp_clear(); exp_preamble(); exp_word(8'hA5, 1'b1);
    fork
      send_word(8'hA5, 1'b1);
      capture(0, 1000, 1, 100, to);
    join
    checks++;
    if (to) begin fails++; $display("FAIL single_timeout got no m_tlast want m_tlast"); end
    checks++;
    if (got_bit.size() != exp_q.size()) begin
      fails++; $display("FAIL single_len got %0d want %0d", got_bit.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_bit.size(); i++) begin
      checks++;
      if ({got_bit[i], got_user[i], got_last[i]} !== {exp_q[i], exp_u[i], exp_l[i]}) begin
        fails++;
        $display("FAIL single_bit%0d got d/u/l=%b%b%b want %b%b%b", i + 1,
                 got_bit[i], got_user[i], got_last[i], exp_q[i], exp_u[i], exp_l[i]);
      end
    end
    checks++;
    if (got_cyc.size() == 19 && (got_cyc[0] != 2 || got_cyc[18] - got_cyc[0] != 18)) begin
      fails++;
      $display("FAIL single_timing got first=%0d span=%0d want first=2 span=18",
               got_cyc[0], got_cyc[18] - got_cyc[0]);
    end
    @(negedge i_clk);
    checks++;
    if (m_tvalid !== 1'b0 || o_busy !== 1'b1) begin
      fails++; $display("FAIL single_gap got v=%b busy=%b want v=0 busy=1", m_tvalid, o_busy);
    end
    repeat (2) @(negedge i_clk);
    checks++;
    if (m_tvalid !== 1'b0 || o_busy !== 1'b0) begin
      fails++; $display("FAIL single_idle got v=%b busy=%b want v=0 busy=0", m_tvalid, o_busy);
    end
  endtask

  task automatic test_stall();
    repeat (4) @(negedge i_clk);
    exp_clear(); exp_preamble(); exp_word(8'hA5, 1'b1);
    fork
      send_word(8'hA5, 1'b1);
      capture(1, 1000, 1, 300, to);
    join
    m_tready = 1'b1;
    checks++;
    if (to) begin fails++; $display("FAIL stall_timeout got no m_tlast want m_tlast"); end
    checks++;
    if (got_bit.size() != exp_q.size()) begin
      fails++; $display("FAIL stall_len got %0d want %0d", got_bit.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_bit.size(); i++) begin
      checks++;
      if ({got_bit[i], got_user[i], got_last[i]} !== {exp_q[i], exp_u[i], exp_l[i]}) begin
        fails++;
        $display("FAIL stall_bit%0d got d/u/l=%b%b%b want %b%b%b", i + 1,
                 got_bit[i], got_user[i], got_last[i], exp_q[i], exp_u[i], exp_l[i]);
      end
    end
    checks++;
    if (stall_err != 0) begin
      fails++; $display("FAIL stall_stable got %0d unstable cycles want 0", stall_err);
    end
  endtask

  task automatic test_underrun();
    repeat (6) @(negedge i_clk);
    exp_clear(); exp_preamble(); exp_word(8'hFF, 1'b0); exp_word(8'h00, 1'b1);
    fork
      begin
        send_word(8'hFF, 1'b0);
        for (int i = 0; i < 100 && o_underrun !== 1'b1; i++) @(negedge i_clk);
        repeat (3) @(negedge i_clk);
        send_word(8'h00, 1'b1);
      end
      capture(0, 1000, 1, 300, to);
    join
    checks++;
    if (to) begin fails++; $display("FAIL underrun_timeout got no m_tlast want m_tlast"); end
    checks++;
    if (got_bit.size() != exp_q.size()) begin
      fails++; $display("FAIL underrun_len got %0d want %0d", got_bit.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_bit.size(); i++) begin
      checks++;
      if ({got_bit[i], got_user[i], got_last[i]} !== {exp_q[i], exp_u[i], exp_l[i]}) begin
        fails++;
        $display("FAIL underrun_bit%0d got d/u/l=%b%b%b want %b%b%b", i + 1,
                 got_bit[i], got_user[i], got_last[i], exp_q[i], exp_u[i], exp_l[i]);
      end
    end
    checks++;
    if (underruns != 1 || uv_valid !== 1'b0) begin
      fails++;
      $display("FAIL underrun_pulse got %0d pulses (m_tvalid=%b) want 1 pulse (m_tvalid=0)",
               underruns, uv_valid);
    end
  endtask

  task automatic test_multiword();
    repeat (6) @(negedge i_clk);
    exp_clear(); exp_preamble(); exp_word(8'h81, 1'b0); exp_word(8'h7E, 1'b1);
    fork
      begin
        send_word(8'h81, 1'b0);
        send_word(8'h7E, 1'b1);
      end
      capture(0, 1000, 1, 200, to);
    join
    checks++;
    if (to) begin fails++; $display("FAIL multi_timeout got no m_tlast want m_tlast"); end
    checks++;
    if (got_bit.size() != exp_q.size()) begin
      fails++; $display("FAIL multi_len got %0d want %0d", got_bit.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_bit.size(); i++) begin
      checks++;
      if ({got_bit[i], got_user[i], got_last[i]} !== {exp_q[i], exp_u[i], exp_l[i]}) begin
        fails++;
        $display("FAIL multi_bit%0d got d/u/l=%b%b%b want %b%b%b", i + 1,
                 got_bit[i], got_user[i], got_last[i], exp_q[i], exp_u[i], exp_l[i]);
      end
    end
    checks++;
    if (got_cyc.size() != 27 || got_cyc[26] - got_cyc[0] != 26 || underruns != 0) begin
      fails++;
      $display("FAIL multi_nobubble got %0d bits, %0d underruns want 27 bits in 27 cycles, 0 underruns",
               got_cyc.size(), underruns);
    end
  endtask

  task automatic test_back_to_back();
    logic rdy_full = 1'b1;
    repeat (6) @(negedge i_clk);
    exp_clear(); exp_preamble(); exp_word(8'h5A, 1'b1); exp_preamble(); exp_word(8'hC3, 1'b1);
    fork
      begin
        send_word(8'h5A, 1'b1);
        rdy_full = s_tready;
        send_word(8'hC3, 1'b1);
      end
      capture(0, 1000, 2, 300, to);
    join
    checks++;
    if (rdy_full !== 1'b0) begin
      fails++; $display("FAIL b2b_ready_full got s_tready=%b want 0", rdy_full);
    end
    checks++;
    if (to) begin fails++; $display("FAIL b2b_timeout got fewer than 2 m_tlast want 2"); end
    checks++;
    if (got_bit.size() != exp_q.size()) begin
      fails++; $display("FAIL b2b_len got %0d want %0d", got_bit.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_bit.size(); i++) begin
      checks++;
      if ({got_bit[i], got_user[i], got_last[i]} !== {exp_q[i], exp_u[i], exp_l[i]}) begin
        fails++;
        $display("FAIL b2b_bit%0d got d/u/l=%b%b%b want %b%b%b", i + 1,
                 got_bit[i], got_user[i], got_last[i], exp_q[i], exp_u[i], exp_l[i]);
      end
    end
    checks++;
    if (got_cyc.size() != 38 || got_cyc[19] - got_cyc[18] != IFG + 2) begin
      fails++;
      $display("FAIL b2b_gap got %0d bits, spacing %0d want 38 bits, spacing %0d",
               got_cyc.size(), (got_cyc.size() > 19) ? got_cyc[19] - got_cyc[18] : -1, IFG + 2);
    end
  endtask

  task automatic test_mid_reset();
    repeat (6) @(negedge i_clk);
    fork
      send_word(8'hA5, 1'b1);
      capture(0, 13, 1, 100, to);
    join
    checks++;
    if (to || got_bit.size() != 13) begin
      fails++; $display("FAIL midrst_pre got %0d bits want 13", got_bit.size());
    end
    @(negedge i_clk);
    checks++;
    if (m_tvalid !== 1'b1 || o_busy !== 1'b1) begin
      fails++; $display("FAIL midrst_bit14 got v=%b busy=%b want v=1 busy=1", m_tvalid, o_busy);
    end
    i_rst_n = 1'b0;
    @(negedge i_clk);
    checks++;
    if ({m_tvalid, m_tdata, m_tlast, m_tuser, o_busy, s_tready} !== 6'b0) begin
      fails++;
      $display("FAIL midrst_outputs got v/d/l/u/busy/rdy=%b%b%b%b%b%b want 000000",
               m_tvalid, m_tdata, m_tlast, m_tuser, o_busy, s_tready);
    end
    i_rst_n = 1'b1;
    exp_clear(); exp_preamble(); exp_word(8'h3C, 1'b1);
    fork
      send_word(8'h3C, 1'b1);
      capture(0, 1000, 1, 100, to);
    join
    checks++;
    if (to || got_bit.size() != exp_q.size()) begin
      fails++; $display("FAIL midrst_len got %0d want %0d", got_bit.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_bit.size(); i++) begin
      checks++;
      if ({got_bit[i], got_user[i], got_last[i]} !== {exp_q[i], exp_u[i], exp_l[i]}) begin
        fails++;
        $display("FAIL midrst_bit%0d got d/u/l=%b%b%b want %b%b%b", i + 1,
                 got_bit[i], got_user[i], got_last[i], exp_q[i], exp_u[i], exp_l[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_stall();
    test_underrun();
    test_multiword();
    test_back_to_back();
    test_mid_reset();
    repeat (4) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
